// File: rtl/robot_key_pkg.sv
// Shared types and defaults for the robot controller key loader.
// Optional parity capture is enabled with ROBOT_KEY_PARITY_EN.
package robot_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_LOCKOUT   = 3'd5
  } state_e;

  localparam int TRIES_W        = 4;
  localparam int SETTLE_W       = 4;
  localparam int KEY_W_DEF      = 8;
  localparam int MAX_TRIES_DEF  = 4;
  localparam int SETTLE_CYC_DEF = 2;

  // XOR-reduce; zero means the word (key plus parity bit) has even parity.
  function automatic logic even_parity(input logic [32:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/robot_key_shreg.sv
// Serial-in parallel-out key register, LSB first, with bit counter.
// done_o flags the cycle in which the final bit is being captured.
module robot_key_shreg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [NBITS-1:0] data_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(NBITS + 1);

  logic [NBITS-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  // Capture one qualified bit into the slot selected by the bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      for (int i = 0; i < NBITS; i++) begin
        if (CNT_W'(i) == cnt_q) data_q[i] <= bit_i;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign data_o = data_q;
  assign done_o = en_i && (cnt_q == CNT_W'(NBITS - 1));

endmodule

// File: rtl/robot_key_loader.sv
// Key loader: serial capture, commit only while the controller idles in s1,
// settle delay, and lockout after MAX_TRIES commits. Parity: ROBOT_KEY_PARITY_EN.
module robot_key_loader
  import robot_key_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int MAX_TRIES  = MAX_TRIES_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               key_sin,
  input  logic               key_sin_vld,
  input  logic               fsm_idle,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               busy,
  output logic               lockout,
  output logic [TRIES_W-1:0] tries
`ifdef ROBOT_KEY_PARITY_EN
  , output logic             err
`endif
);

`ifdef ROBOT_KEY_PARITY_EN
  localparam int NBITS = KEY_W + 1;
`else
  localparam int NBITS = KEY_W;
`endif

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      key_q;
  logic                  key_valid_q, busy_q, lockout_q;
  logic [TRIES_W-1:0]    tries_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic [NBITS-1:0]      sh_data;
  logic                  sh_done, sh_clr, sh_en, par_ok, settle_done, at_limit;

  assign sh_clr      = (state_q == ST_IDLE) && load_start;
  assign sh_en       = (state_q == ST_SHIFT) && key_sin_vld;
  assign settle_done = (settle_q == SETTLE_W'(SETTLE_CYC - 1));
  assign at_limit    = (tries_q == TRIES_W'(MAX_TRIES));

`ifdef ROBOT_KEY_PARITY_EN
  logic err_q;
  assign par_ok = ~even_parity(33'(sh_data));
  assign err    = err_q;
`else
  assign par_ok = 1'b1;
`endif

  robot_key_shreg #(.NBITS(NBITS)) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sh_clr),
    .en_i   (sh_en),
    .bit_i  (key_sin),
    .data_o (sh_data),
    .done_o (sh_done)
  );

  // Next-state selection; lockout is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (load_start) state_d = ST_SHIFT;     else state_d = state_q;
      ST_SHIFT:     if (sh_done)    state_d = ST_WAIT_IDLE; else state_d = state_q;
      ST_WAIT_IDLE: if (fsm_idle)   state_d = ST_COMMIT;    else state_d = state_q;
      ST_COMMIT:    state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_done) state_d = at_limit ? ST_LOCKOUT : ST_IDLE;
        else             state_d = state_q;
      end
      ST_LOCKOUT:   state_d = ST_LOCKOUT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register, registered status outputs, commit and settle datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lockout_q   <= 1'b0;
      tries_q     <= '0;
      settle_q    <= '0;
`ifdef ROBOT_KEY_PARITY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_LOCKOUT);
      lockout_q <= (state_d == ST_LOCKOUT);
`ifdef ROBOT_KEY_PARITY_EN
      err_q     <= (state_q == ST_COMMIT) && !par_ok;
`endif
      case (state_q)
        ST_COMMIT: begin
          key_valid_q <= 1'b0;
          settle_q    <= '0;
          if (par_ok) key_q <= sh_data[KEY_W-1:0];
          // A rejected key still consumes an attempt.
          if (!at_limit) tries_q <= tries_q + TRIES_W'(1);
        end
        ST_SETTLE: begin
          if (settle_done) begin
            key_valid_q <= 1'b1;
            settle_q    <= '0;
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign lockout   = lockout_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_robot_key_loader.sv
// Directed bench for robot_key_loader with a key_out scoreboard checked on
// every key_valid rise. Exercises the parity path when ROBOT_KEY_PARITY_EN is set.
module tb_robot_key_loader;

  logic       clk = 1'b0;
  logic       rst, load_start, key_sin, key_sin_vld, fsm_idle;
  logic [7:0] key_out;
  logic       key_valid, busy, lockout;
  logic [3:0] tries;
`ifdef ROBOT_KEY_PARITY_EN
  logic       err;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic       kv_prev = 1'b0;

  robot_key_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .key_sin     (key_sin),
    .key_sin_vld (key_sin_vld),
    .fsm_idle    (fsm_idle),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .busy        (busy),
    .lockout     (lockout),
    .tries       (tries)
`ifdef ROBOT_KEY_PARITY_EN
    , .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Serial key bits LSB first (plus parity bit when enabled); ends just after the last-bit edge.
  task automatic send(input logic [7:0] k, input bit stall, input bit flip, input int glitch_at);
    int nb;
    nb = 8;
`ifdef ROBOT_KEY_PARITY_EN
    nb = 9;
`endif
    for (int i = 0; i < nb; i++) begin
      key_sin     = (i < 8) ? k[i] : ((^k) ^ flip);
      key_sin_vld = 1'b1;
      load_start  = (i == glitch_at);
      tick();
      load_start  = 1'b0;
      if (stall && i < nb - 1) begin
        key_sin_vld = 1'b0;
        tick();
      end
    end
    key_sin_vld = 1'b0;
    key_sin     = 1'b0;
  endtask

  // Scoreboard: each key_valid rise must present the next expected key.
  always @(negedge clk) begin : sb_mon
    logic [7:0] e;
    if (key_valid && !kv_prev) begin
      chk("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_key_out", key_out, e);
      end
    end
    kv_prev = key_valid;
  end

  initial begin
    rst = 1'b0; load_start = 1'b0; key_sin = 1'b0; key_sin_vld = 1'b0; fsm_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_out", key_out, 8'h00);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lockout", lockout, 1'b0);
    chk("rst_tries", tries, 4'd0);
    rst = 1'b1;
    tick();

    // Basic load of 0xA5 with the controller already idle.
    start();
    chk("shift_busy", busy, 1'b1);
    sb_q.push_back(8'hA5);
    send(8'hA5, 1'b0, 1'b0, -1);
    chk("a5_wait_hold", key_out, 8'h00);
    tick();
    chk("a5_commit_hold", key_out, 8'h00);
    tick();
    chk("a5_key_out", key_out, 8'hA5);
    chk("a5_kv_low", key_valid, 1'b0);
    chk("a5_tries", tries, 4'd1);
    tick();
    chk("a5_settle1", key_valid, 1'b0);
    tick();
    chk("a5_kv", key_valid, 1'b1);
    chk("a5_busy_done", busy, 1'b0);

    // Stalled bits and a controller that is not idle for ten cycles.
    fsm_idle = 1'b0;
    start();
    sb_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0, -1);
    for (int c = 0; c < 10; c++) begin
      chk("gate_key_hold", key_out, 8'hA5);
      chk("gate_busy", busy, 1'b1);
      tick();
    end
    fsm_idle = 1'b1;
    tick();
    chk("gate_commit_hold", key_out, 8'hA5);
    tick();
    chk("gate_key_out", key_out, 8'h3C);
    chk("gate_tries", tries, 4'd2);
    fsm_idle = 1'b0;
    tick();
    tick();
    chk("gate_kv_idle_drop", key_valid, 1'b1);
    fsm_idle = 1'b1;

    // load_start pulsed during SHIFT and SETTLE must not restart anything.
    start();
    sb_q.push_back(8'h5A);
    send(8'h5A, 1'b0, 1'b0, 3);
    tick();
    tick();
    chk("ign_key_out", key_out, 8'h5A);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    chk("ign_kv", key_valid, 1'b1);
    chk("ign_tries", tries, 4'd3);
    tick();
    chk("ign_busy", busy, 1'b0);

    // Fourth commit reaches the limit; a fifth load is ignored.
    start();
    sb_q.push_back(8'h77);
    send(8'h77, 1'b0, 1'b0, -1);
    repeat (4) tick();
    chk("lock_lockout", lockout, 1'b1);
    chk("lock_tries", tries, 4'd4);
    chk("lock_key_out", key_out, 8'h77);
    chk("lock_busy", busy, 1'b0);
    start();
    send(8'hEE, 1'b0, 1'b0, -1);
    repeat (6) tick();
    chk("lock5_key_out", key_out, 8'h77);
    chk("lock5_busy", busy, 1'b0);
    chk("lock5_tries", tries, 4'd4);
    chk("lock5_kv", key_valid, 1'b1);

    // Reset part-way through a load, then a clean load of 0x81.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start();
    for (int i = 0; i < 5; i++) begin
      key_sin     = i[0];
      key_sin_vld = 1'b1;
      tick();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_key_out", key_out, 8'h00);
    chk("mid_rst_kv", key_valid, 1'b0);
    chk("mid_rst_tries", tries, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_lockout", lockout, 1'b0);
    key_sin_vld = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start();
    sb_q.push_back(8'h81);
    send(8'h81, 1'b0, 1'b0, -1);
    repeat (4) tick();
    chk("r81_key_out", key_out, 8'h81);
    chk("r81_kv", key_valid, 1'b1);
    chk("r81_tries", tries, 4'd1);
    chk("r81_busy", busy, 1'b0);

`ifdef ROBOT_KEY_PARITY_EN
    // Wrong parity: rejected but counted; then the same key with good parity.
    start();
    sb_q.push_back(8'h81);
    send(8'h0F, 1'b0, 1'b1, -1);
    tick();
    tick();
    chk("par_err_pulse", err, 1'b1);
    chk("par_bad_key_out", key_out, 8'h81);
    chk("par_bad_tries", tries, 4'd2);
    tick();
    chk("par_err_clear", err, 1'b0);
    tick();
    start();
    sb_q.push_back(8'h0F);
    send(8'h0F, 1'b0, 1'b0, -1);
    tick();
    tick();
    chk("par_good_err", err, 1'b0);
    chk("par_good_key_out", key_out, 8'h0F);
    chk("par_good_tries", tries, 4'd3);
    tick();
    tick();
`endif

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
